regfile_port_arbiter: RTL

Sits between the CPU core and the 32×32-bit register file and shares the file's single write port and its Rs1 read port between two requesters. The core has default priority. A secondary agent (the interrupt/debug unit) is served through a req/gnt handshake, with a starvation limit that forces the agent in. An optional sequencer zeroes x1..x31 one register per cycle on request.

---
 rtl/regfile_arb_pkg.sv | 13 +
 rtl/regfile_port_arbiter_if.sv | 42 ++++
 rtl/rf_clear_seq.sv | 33 +++
 rtl/regfile_port_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared widths and FSM state type for the register-file port arbiter.
package regfile_arb_pkg;

    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_LAST_IDX = 31;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } arb_state_e;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Core, agent, register-file and clear signals of the arbiter.
// The master side drives requests and the register-file read data.
interface regfile_port_arbiter_if;
    import regfile_arb_pkg::*;

    logic                 cpu_we;
    logic [RF_ADDR_W-1:0] cpu_wa;
    logic [RF_DATA_W-1:0] cpu_wd;
    logic [RF_ADDR_W-1:0] cpu_rs1_addr;
    logic                 cpu_rs1_used;
    logic                 cpu_stall;
    logic                 agt_req;
    logic                 agt_we;
    logic [RF_ADDR_W-1:0] agt_addr;
    logic [RF_DATA_W-1:0] agt_wd;
    logic                 agt_gnt;
    logic                 agt_rvalid;
    logic [RF_DATA_W-1:0] agt_rdata;
    logic [RF_DATA_W-1:0] rf_rs1_data;
    logic                 rf_we;
    logic [RF_ADDR_W-1:0] rf_wa;
    logic [RF_DATA_W-1:0] rf_wd;
    logic [RF_ADDR_W-1:0] rf_rs1_addr;
    logic                 clr_start;
    logic                 clr_busy;
    logic                 clr_done;

    modport master (
        output cpu_we, cpu_wa, cpu_wd, cpu_rs1_addr, cpu_rs1_used,
        output agt_req, agt_we, agt_addr, agt_wd, rf_rs1_data, clr_start,
        input  cpu_stall, agt_gnt, agt_rvalid, agt_rdata,
        input  rf_we, rf_wa, rf_wd, rf_rs1_addr, clr_busy, clr_done
    );

    modport slave (
        input  cpu_we, cpu_wa, cpu_wd, cpu_rs1_addr, cpu_rs1_used,
        input  agt_req, agt_we, agt_addr, agt_wd, rf_rs1_data, clr_start,
        output cpu_stall, agt_gnt, agt_rvalid, agt_rdata,
        output rf_we, rf_wa, rf_wd, rf_rs1_addr, clr_busy, clr_done
    );

endinterface

// File: rtl/rf_clear_seq.sv
// Clear sequencer: steps clr_idx over x1..x31 while active and pulses done
// in the cycle after the last index is written.
module rf_clear_seq
    import regfile_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 active,
    output logic [RF_ADDR_W-1:0] idx,
    output logic                 last,
    output logic                 done
);

    logic [RF_ADDR_W-1:0] idx_q;
    logic                 done_q;

    assign idx  = idx_q;
    assign last = (idx_q == RF_ADDR_W'(RF_LAST_IDX));
    assign done = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= RF_ADDR_W'(1);
            done_q <= 1'b0;
        end else begin
            done_q <= active && last;
            if (active) begin
                idx_q <= last ? RF_ADDR_W'(1) : idx_q + RF_ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register-file write port and Rs1 read port between the core and
// an agent with starvation forcing. RF_ARB_CLEAR_EN adds the x1..x31 clear.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_port_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e           state_q;
    logic [3:0]           starve_q;
    logic                 rvalid_q;
    logic [RF_DATA_W-1:0] rdata_q;
    logic                 clr_go;
    logic                 clr_active;
    logic                 clr_last;
    logic                 clr_done_pulse;
    logic [RF_ADDR_W-1:0] clr_idx;
    logic                 forced;
    logic                 natural;
    logic                 gnt;
    logic                 stall;

`ifdef RF_ARB_CLEAR_EN
    assign clr_active = (state_q == ST_CLEAR);
    assign clr_go     = (state_q == ST_IDLE) && bus.clr_start;

    rf_clear_seq u_clear_seq (
        .clk    (clk),
        .rst    (rst),
        .active (clr_active),
        .idx    (clr_idx),
        .last   (clr_last),
        .done   (clr_done_pulse)
    );
`else
    logic unused_clr_start;
    assign unused_clr_start = bus.clr_start;
    assign clr_active       = 1'b0;
    assign clr_go           = 1'b0;
    assign clr_last         = 1'b0;
    assign clr_done_pulse   = 1'b0;
    assign clr_idx          = '0;
`endif

    assign forced  = bus.agt_req && (starve_q == LIMIT);
    assign natural = bus.agt_req && (bus.agt_we ? !bus.cpu_we : !bus.cpu_rs1_used);

    always_comb begin
        gnt             = 1'b0;
        stall           = 1'b0;
        bus.rf_we       = bus.cpu_we;
        bus.rf_wa       = bus.cpu_wa;
        bus.rf_wd       = bus.cpu_wd;
        bus.rf_rs1_addr = bus.cpu_rs1_addr;
        if (rst) begin
            bus.rf_we = 1'b0;
        end else if (clr_active) begin
            bus.rf_we = 1'b1;
            bus.rf_wa = clr_idx;
            bus.rf_wd = '0;
            stall     = 1'b1;
        end else if (!clr_go && (forced || natural)) begin
            gnt   = 1'b1;
            // A forced grant stalls the core, so its write is dropped.
            stall = forced;
            if (bus.agt_we) begin
                bus.rf_we = 1'b1;
                bus.rf_wa = bus.agt_addr;
                bus.rf_wd = bus.agt_wd;
            end else begin
                bus.rf_we       = bus.cpu_we && !forced;
                bus.rf_rs1_addr = bus.agt_addr;
            end
        end
    end

    assign bus.agt_gnt    = gnt;
    assign bus.cpu_stall  = stall;
    assign bus.agt_rvalid = rvalid_q;
    assign bus.agt_rdata  = rdata_q;
    assign bus.clr_busy   = clr_active;
    assign bus.clr_done   = clr_done_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt && !bus.agt_we;
            if (gnt && !bus.agt_we) begin
                rdata_q <= bus.rf_rs1_data;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (!bus.agt_req || gnt) begin
                        starve_q <= '0;
                    end else if (starve_q != LIMIT) begin
                        starve_q <= starve_q + 4'd1;
                    end
                    if (clr_go) begin
                        state_q <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
